// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide path: MDOp encodings, default
// latencies (common to the mult/div unit and its issue controller) and FSM states.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_stall_counter.sv
// Free-running event counter: adds one on every edge where inc is high,
// wrapping silently at 2^W.
module md_stall_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the mult/div unit: start pulses, shadow busy
// countdown, D-stage stall generation, stall statistics and Busy cross-check.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_md_use,
    input  logic        e_md_req,
    input  logic [2:0]  e_mdop,
    input  logic        e_flush,
    input  logic        md_busy,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        stall_d,
    output logic        busy,
    output logic [31:0] stall_cnt,
    output logic        busy_mismatch
);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;

    assign busy  = (state != ST_IDLE);
    assign md_op = e_mdop;

    // NOTE: start and stall are combinational so a request arriving on the
    // cycle busy falls issues with no bubble; everything else is a flop.
    assign md_start = e_md_req & ~e_flush & ~busy & (e_mdop <= MD_MTLO);
    assign stall_d  = d_md_use & (busy | (md_start & (e_mdop <= MD_DIVU)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            busy_mismatch <= 1'b0;
        end else begin
            if (busy != md_busy) begin
                busy_mismatch <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // mthi/mtlo complete on the start edge and leave us idle.
                    if (md_start && e_mdop <= MD_MULTU) begin
                        state <= ST_MUL;
                        cnt   <= CNT_W'(MULT_CYCLES - 1);
                    end else if (md_start && e_mdop <= MD_DIVU) begin
                        state <= ST_DIV;
                        cnt   <= CNT_W'(DIV_CYCLES - 1);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    md_stall_counter #(
        .W(32)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_d),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios plus a randomized
// run against a cycle-count model of the mult/div issue rules.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_md_use;
    logic        e_md_req;
    logic [2:0]  e_mdop;
    logic        e_flush;
    logic        md_busy;
    logic        md_start;
    logic [2:0]  md_op;
    logic        stall_d;
    logic        busy;
    logic [31:0] stall_cnt;
    logic        busy_mismatch;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: remaining busy cycles of the running operation.
    int          rem_m   = 0;
    logic [31:0] cnt_m   = '0;
    logic        mm_m    = 1'b0;
    logic        force_busy = 1'b0;

    always #5 clk = ~clk;

    md_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .d_md_use      (d_md_use),
        .e_md_req      (e_md_req),
        .e_mdop        (e_mdop),
        .e_flush       (e_flush),
        .md_busy       (md_busy),
        .md_start      (md_start),
        .md_op         (md_op),
        .stall_d       (stall_d),
        .busy          (busy),
        .stall_cnt     (stall_cnt),
        .busy_mismatch (busy_mismatch)
    );

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(busy && md_start)) else $error("md_start issued while busy");
        end
    end

    function automatic logic start_exp();
        return e_md_req && !e_flush && rem_m == 0 && e_mdop <= 3'd5;
    endfunction

    function automatic logic stall_exp();
        return d_md_use && (rem_m > 0 || (start_exp() && e_mdop <= 3'd3));
    endfunction

    function automatic int op_cycles(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Advance one clock edge, updating the model; md_busy emulates the unit.
    task automatic tick();
        logic s, st, b;
        s  = start_exp();
        st = stall_exp();
        b  = (rem_m > 0);
        @(posedge clk);
        if (reset) begin
            rem_m = 0;
            cnt_m = '0;
            mm_m  = 1'b0;
        end else begin
            if (st) cnt_m = cnt_m + 32'd1;
            if (b != md_busy) mm_m = 1'b1;
            if (rem_m > 0) rem_m = rem_m - 1;
            else if (s) rem_m = op_cycles(e_mdop);
        end
        #1;
        if (!force_busy) md_busy = (rem_m > 0);
    endtask

    task automatic idle_inputs();
        d_md_use = 1'b0;
        e_md_req = 1'b0;
        e_mdop   = 3'd0;
        e_flush  = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        md_busy = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        tests_run++;
        if (busy_mismatch !== 1'b0) begin tests_failed++; $display("FAIL reset_mismatch: got %b want 0", busy_mismatch); end
        tests_run++;
        if (md_start !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++; $display("FAIL reset_comb: md_start=%b stall_d=%b want 0 0", md_start, stall_d);
        end
    endtask

    task automatic test_mult();
        int n;
        e_md_req = 1'b1;
        e_mdop   = 3'd0;
        #1;
        tests_run++;
        if (md_start !== 1'b1 || md_op !== 3'd0) begin
            tests_failed++; $display("FAIL mult_start: md_start=%b md_op=%0d want 1 0", md_start, md_op);
        end
        tick();
        e_md_req = 1'b0;
        #1;
        tests_run++;
        if (md_start !== 1'b0) begin tests_failed++; $display("FAIL mult_pulse: md_start=%b want 0", md_start); end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        tests_run++;
        if (n != 5) begin tests_failed++; $display("FAIL mult_busy_len: got %0d cycles want 5", n); end
        tests_run++;
        if (busy_mismatch !== 1'b0) begin tests_failed++; $display("FAIL mult_mismatch: got %b want 0", busy_mismatch); end
    endtask

    task automatic test_div_stall();
        int n;
        logic [31:0] c0;
        c0 = stall_cnt;
        d_md_use = 1'b1;
        e_md_req = 1'b1;
        e_mdop   = 3'd2;
        #1;
        tests_run++;
        if (stall_d !== 1'b1) begin tests_failed++; $display("FAIL div_stall_start: got %b want 1", stall_d); end
        n = 1;
        tick();
        e_md_req = 1'b0;
        #1;
        while (stall_d === 1'b1 && n < 30) begin
            n++;
            tick();
            #1;
        end
        tests_run++;
        if (n != 11) begin tests_failed++; $display("FAIL div_stall_len: got %0d cycles want 11", n); end
        tests_run++;
        if (stall_cnt - c0 !== 32'd11) begin
            tests_failed++; $display("FAIL div_stall_cnt: got %0d want 11", stall_cnt - c0);
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL div_done_busy: got %b want 0", busy); end
        idle_inputs();
    endtask

    task automatic test_mthi();
        d_md_use = 1'b1;
        e_md_req = 1'b1;
        e_mdop   = 3'd4;
        #1;
        tests_run++;
        if (md_start !== 1'b1 || stall_d !== 1'b0) begin
            tests_failed++; $display("FAIL mthi_issue: md_start=%b stall_d=%b want 1 0", md_start, stall_d);
        end
        tick();
        e_md_req = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++; $display("FAIL mthi_after: busy=%b stall_d=%b want 0 0", busy, stall_d);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        d_md_use = 1'b1;
        e_md_req = 1'b1;
        e_flush  = 1'b1;
        e_mdop   = 3'd1;
        #1;
        tests_run++;
        if (md_start !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++; $display("FAIL flush_comb: md_start=%b stall_d=%b want 0 0", md_start, stall_d);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        d_md_use = 1'b1;
        e_md_req = 1'b1;
        e_mdop   = 3'd3;
        #1;
        tick();
        e_md_req = 1'b0;
        tick();
        tick();
        #1;
        tests_run++;
        if (busy !== 1'b1 || stall_cnt !== cnt_m) begin
            tests_failed++; $display("FAIL rstmid_pre: busy=%b stall_cnt=%0d want 1 %0d", busy, stall_cnt, cnt_m);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_md_use = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || stall_cnt !== 32'd0 || busy_mismatch !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_post: busy=%b stall_cnt=%0d mismatch=%b want 0 0 0", busy, stall_cnt, busy_mismatch);
        end
        tick();
        #1;
        tests_run++;
        if (busy !== 1'b0 || stall_d !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_idle: busy=%b stall_d=%b want 0 0", busy, stall_d);
        end
        idle_inputs();
    endtask

    task automatic test_mismatch();
        e_md_req = 1'b1;
        e_mdop   = 3'd0;
        #1;
        tick();
        idle_inputs();
        force_busy = 1'b1;
        md_busy    = 1'b0;
        #1;
        tests_run++;
        if (busy_mismatch !== 1'b0) begin tests_failed++; $display("FAIL mm_before: got %b want 0", busy_mismatch); end
        tick();
        tests_run++;
        if (busy_mismatch !== 1'b1) begin tests_failed++; $display("FAIL mm_rise: got %b want 1", busy_mismatch); end
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (busy_mismatch !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL mm_hold: mismatch=%b busy=%b want 1 0", busy_mismatch, busy);
        end
        force_busy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (busy_mismatch !== 1'b0) begin tests_failed++; $display("FAIL mm_clear: got %b want 0", busy_mismatch); end
    endtask

    task automatic test_back_to_back();
        int n;
        e_md_req = 1'b1;
        e_mdop   = 3'd0;
        #1;
        tick();
        e_mdop = 3'd2;
        #1;
        n = 0;
        while (md_start !== 1'b1 && n < 20) begin
            n++;
            tick();
            #1;
        end
        tests_run++;
        if (n != 5 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_issue: waited %0d cycles busy=%b want 5 0", n, busy);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_div_busy: got %b want 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        tests_run++;
        if (n != 10) begin tests_failed++; $display("FAIL b2b_div_len: got %0d cycles want 10", n); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            d_md_use = $urandom_range(0, 1) == 1;
            e_md_req = ($urandom_range(0, 2) == 0);
            e_flush  = ($urandom_range(0, 5) == 0);
            e_mdop   = 3'($urandom_range(0, 7));
            #1;
            tests_run++;
            if (md_start !== start_exp() || stall_d !== stall_exp() || md_op !== e_mdop) begin
                tests_failed++;
                $display("FAIL rand_comb[%0d]: md_start=%b stall_d=%b md_op=%0d want %b %b %0d",
                         i, md_start, stall_d, md_op, start_exp(), stall_exp(), e_mdop);
            end
            tick();
            tests_run++;
            if (busy !== (rem_m > 0) || stall_cnt !== cnt_m || busy_mismatch !== mm_m) begin
                tests_failed++;
                $display("FAIL rand_reg[%0d]: busy=%b stall_cnt=%0d mismatch=%b want %b %0d %b",
                         i, busy, stall_cnt, busy_mismatch, rem_m > 0, cnt_m, mm_m);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_stall();
        test_mthi();
        test_flush();
        test_reset_mid();
        test_mismatch();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller for the pipeline's multiply/divide unit. It sits between the E stage and the mult/div unit. It turns E-stage MD instructions into single-cycle start pulses and shadows the unit's busy period with its own countdown. It stalls the D stage whenever an MD-class instruction would read or overwrite HI/LO too early. It also keeps a stall-cycle counter and a sticky mismatch flag that checks the unit's Busy output against the shadow.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start edge. Must match the mult/div unit.
- DIV_CYCLES, 10, busy cycles after a div/divu start edge. Must match the mult/div unit.
- CNT_W, 4, countdown width. Must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- e_md_req  in  1  E-stage instruction is mult/multu/div/divu/mthi/mtlo.
- e_mdop  in  3  MDOp of the E instruction: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo.
- e_flush  in  1  E instruction is being cancelled this cycle.
- md_busy  in  1  Busy output of the mult/div unit.
- md_start  out  1  start pulse to the mult/div unit.
- md_op  out  3  MDOp to the mult/div unit. Equals e_mdop.
- stall_d  out  1  freeze F/D and bubble E.
- busy  out  1  shadow busy.
- stall_cnt  out  32  count of cycles with stall_d=1.
- busy_mismatch  out  1  sticky: shadow busy != md_busy.

## Operation
- Internal state: cnt[CNT_W-1:0]. FSM states IDLE, MUL, DIV. busy = (state != IDLE).
- md_start = e_md_req & ~e_flush & (state==IDLE) & (e_mdop <= 5). Combinational.
- On a clock edge with md_start=1:
  - e_mdop 0/1: state←MUL, cnt←MULT_CYCLES-1.
  - e_mdop 2/3: state←DIV, cnt←DIV_CYCLES-1.
  - e_mdop 4/5: state stays IDLE. The unit writes HI/LO on that same edge.
- In MUL/DIV: cnt decrements each edge. On the edge where cnt==0, state←IDLE.
- stall_d = d_md_use & (busy | (md_start & e_mdop <= 3)).
  - A D-stage MD instruction never enters E while an operation is running.
  - The stall covers the full busy window, including the result-write edge.
- e_md_req while busy is a protocol violation. It cannot occur while stall_d works. md_start stays 0, and this is asserted in the bench.
- e_mdop 6/7 is ignored: no start, no state change.
- stall_cnt increments every edge with stall_d=1. It wraps at 2^32 with no saturation.
- busy_mismatch is set on any edge where busy != md_busy. It is cleared only by reset.

## Timing
- Reset values: state IDLE, cnt 0, busy 0, md_start 0 (given IDLE and no req), stall_d 0, stall_cnt 0, busy_mismatch 0.
- Start edge t0. For mult, busy=1 during cycles t0+1 … t0+MULT_CYCLES. The unit writes the result at edge t0+MULT_CYCLES, and busy=0 from then on.
  - A D-stage mfhi stalled behind it proceeds on edge t0+MULT_CYCLES+1.
- Div is identical with DIV_CYCLES.
- Back-to-back: an MD request arriving in E on the cycle busy falls issues immediately. There are no idle bubbles.
- e_flush together with e_md_req: no start, no stall contribution from E.
- reset mid-operation: the FSM returns to IDLE and cnt to 0 on that edge. The unit resets too, so no mismatch is flagged.
- All outputs except md_start, md_op and stall_d are registered.

## Structure
- Shared package md_pkg:
  - MDOp localparams (MD_MULT … MD_MTLO).
  - FSM state typedef.
  - Default MULT_CYCLES and DIV_CYCLES. The mult/div unit and this block use the same constants.
- No sub-module is needed. Optionally split out md_stall_counter for the 32-bit counter; it is natural but not required.

## Test plan
- Reset, then mult with MDOp=0 and d_md_use=0: md_start high for 1 cycle, busy high exactly 5 cycles, busy_mismatch stays 0.
- div (MDOp=2) in E with mflo in D: stall_d=1 for 11 consecutive cycles (start cycle plus 10). stall_cnt=11 afterwards.
- mthi (MDOp=4) followed by mfhi in D: md_start pulses, busy stays 0, stall_d=0.
- e_md_req=1, e_flush=1, MDOp=1: md_start=0, busy stays 0, no stall.
- reset asserted on the 3rd busy cycle of a div: busy=0, state IDLE, and stall_cnt=0 on the next cycle.
- Force md_busy=0 while a shadow mult is running: busy_mismatch rises on the next edge and holds until reset.
